// File: rtl/dd_pkg.sv
// -----------------------------------------------------------------------------
// dd_pkg
// Shared definitions for the DD arithmetic-unit sequencer:
//   - DW        : data width of registers and AU operands
//   - AC_*      : AU opcode constants (sequencer opcodes are AU-aligned)
//   - state_t   : sequencer FSM states
//   - is_legal  : true for opcodes the sequencer issues to the AU
// -----------------------------------------------------------------------------
package dd_pkg;

   localparam int DW = 8;

   localparam logic [3:0] AC_ADD  = 4'b1000;
   localparam logic [3:0] AC_SUB  = 4'b1001;
   localparam logic [3:0] AC_MOV  = 4'b0100;
   localparam logic [3:0] AC_LDI  = 4'b0101;
   localparam logic [3:0] AC_MOVG = 4'b1101;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      ISSUE  = 3'd2,
      WB     = 3'd3,
      ERR    = 3'd4
   } state_t;

   function automatic logic is_legal(input logic [3:0] op);
      return (op == AC_ADD) || (op == AC_SUB) || (op == AC_MOV) ||
             (op == AC_LDI) || (op == AC_MOVG);
   endfunction

endpackage

// File: rtl/dd_regfile.sv
// -----------------------------------------------------------------------------
// dd_regfile
// NREG x DW register file for the AU sequencer.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (clears all regs)
//   we, wsel, wdata    : synchronous write port
//   ra_sel / ra_data   : asynchronous operand read port A
//   rb_sel / rb_data   : asynchronous operand read port B
//   rd_sel / rd_data   : asynchronous debug read port
// -----------------------------------------------------------------------------
module dd_regfile #(
   parameter int DW   = 8,
   parameter int NREG = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [1:0]    wsel,
   input  logic [DW-1:0] wdata,
   input  logic [1:0]    ra_sel,
   output logic [DW-1:0] ra_data,
   input  logic [1:0]    rb_sel,
   output logic [DW-1:0] rb_data,
   input  logic [1:0]    rd_sel,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_reg [NREG];

   // Every register must clear on reset, so each entry is its own flop bank
   // rather than an inferred RAM.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_reg[gi] <= '0;
            end else if (we && (wsel == 2'(gi))) begin
               mem_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign ra_data = mem_reg[ra_sel];
   assign rb_data = mem_reg[rb_sel];
   assign rd_data = mem_reg[rd_sel];

endmodule

// File: rtl/dd_au_seq.sv
// -----------------------------------------------------------------------------
// dd_au_seq
// Non-pipelined execution sequencer driving the DD arithmetic unit (AU).
// Each accepted 12-bit instruction walks IDLE -> DECODE -> ISSUE -> WB
// (or IDLE -> DECODE -> ERR for an illegal opcode): 4 cycles per instruction.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : instruction handshake (ready only in IDLE)
//   in_instr[11:0]          : [11:8] op, [7:6] dst, [5:4] srcA, [3:2] srcB;
//                             LDI uses [5:0] as a zero-extended immediate
//   au_en, au_ac, au_a, au_b: AU command, all zero outside ISSUE
//   au_t, au_gf             : combinational AU result and greater flag
//   done                    : one-cycle retire pulse (WB)
//   err                     : one-cycle illegal-opcode pulse
//   g_flag                  : compare flag stored by SUB, consumed by MOVG
//   rd_sel / rd_data        : asynchronous register read port
//   retired[15:0]           : retire counter, present only when the macro
//                             DD_AU_SEQ_PERF_EN is defined
// -----------------------------------------------------------------------------
module dd_au_seq
   import dd_pkg::*;
#(
   parameter int DW   = dd_pkg::DW,
   parameter int NREG = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [11:0]   in_instr,
   output logic          au_en,
   output logic [3:0]    au_ac,
   output logic [DW-1:0] au_a,
   output logic [DW-1:0] au_b,
   input  logic [DW-1:0] au_t,
   input  logic          au_gf,
   output logic          done,
   output logic          err,
   output logic          g_flag,
   input  logic [1:0]    rd_sel,
   output logic [DW-1:0] rd_data
`ifdef DD_AU_SEQ_PERF_EN
   ,
   output logic [15:0]   retired
`endif
);

   state_t        state_reg, state_next;
   logic [11:0]   instr_reg;
   logic [DW-1:0] opa_reg, opb_reg;
   logic [DW-1:0] res_reg;
   logic          gf_reg;
   logic          g_flag_reg;

   logic [3:0]    op;
   logic [1:0]    dst_sel, sa_sel, sb_sel;
   logic [DW-1:0] ra_data, rb_data;
   logic          rf_we;

   assign op      = instr_reg[11:8];
   assign dst_sel = instr_reg[7:6];
   assign sa_sel  = instr_reg[5:4];
   assign sb_sel  = instr_reg[3:2];

   // MOVG retires either way; it only writes when the stored flag is set.
   assign rf_we = (state_reg == WB) && ((op != AC_MOVG) || g_flag_reg);

   dd_regfile #(
      .DW   (DW),
      .NREG (NREG)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .wsel    (dst_sel),
      .wdata   (res_reg),
      .ra_sel  (sa_sel),
      .ra_data (ra_data),
      .rb_sel  (sb_sel),
      .rb_data (rb_data),
      .rd_sel  (rd_sel),
      .rd_data (rd_data)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = DECODE;
         DECODE:  state_next = is_legal(op) ? ISSUE : ERR;
         ISSUE:   state_next = WB;
         WB:      state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         instr_reg  <= '0;
         opa_reg    <= '0;
         opb_reg    <= '0;
         res_reg    <= '0;
         gf_reg     <= 1'b0;
         g_flag_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (in_valid) instr_reg <= in_instr;
            end
            DECODE: begin
               // LDI routes its immediate through the AU on operand a.
               if (op == AC_LDI) begin
                  opa_reg <= {{(DW-6){1'b0}}, instr_reg[5:0]};
                  opb_reg <= '0;
               end else begin
                  opa_reg <= ra_data;
                  opb_reg <= rb_data;
               end
            end
            ISSUE: begin
               res_reg <= au_t;
               gf_reg  <= au_gf;
            end
            WB: begin
               if (op == AC_SUB) g_flag_reg <= gf_reg;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from state so an asynchronous reset returns
   // them to their idle values without waiting for a clock.
   assign in_ready = (state_reg == IDLE);
   assign au_en    = (state_reg == ISSUE);
   assign au_ac    = au_en ? op : 4'b0000;
   assign au_a     = au_en ? opa_reg : '0;
   assign au_b     = au_en ? opb_reg : '0;
   assign done     = (state_reg == WB);
   assign err      = (state_reg == ERR);
   assign g_flag   = g_flag_reg;

`ifdef DD_AU_SEQ_PERF_EN
   logic [15:0] retired_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_reg <= '0;
      end else if (state_reg == WB) begin
         retired_reg <= retired_reg + 16'd1;
      end
   end

   assign retired = retired_reg;
`endif

endmodule

// File: tb/tb_dd_au_seq.sv
// -----------------------------------------------------------------------------
// tb_dd_au_seq
// Directed bench for dd_au_seq with a combinational AU model.
// Build with DD_AU_SEQ_PERF_EN defined to also cover the retire counter.
// -----------------------------------------------------------------------------
module tb_dd_au_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_instr;
   logic        au_en;
   logic [3:0]  au_ac;
   logic [7:0]  au_a, au_b, au_t;
   logic        au_gf;
   logic        done, err, g_flag;
   logic [1:0]  rd_sel;
   logic [7:0]  rd_data;
`ifdef DD_AU_SEQ_PERF_EN
   logic [15:0] retired;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_done_cyc = 0;

   dd_au_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .au_en    (au_en),
      .au_ac    (au_ac),
      .au_a     (au_a),
      .au_b     (au_b),
      .au_t     (au_t),
      .au_gf    (au_gf),
      .done     (done),
      .err      (err),
      .g_flag   (g_flag),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data)
`ifdef DD_AU_SEQ_PERF_EN
      ,
      .retired  (retired)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // AU model: ADD a+b, SUB b-a, moves pass a; gf is a signed b > a.
   always_comb begin
      au_t  = 8'h00;
      au_gf = ($signed(au_b) > $signed(au_a));
      case (au_ac)
         4'b1000: au_t = au_a + au_b;
         4'b1001: au_t = au_b - au_a;
         4'b0100, 4'b0101, 4'b1101: au_t = au_a;
         default: au_t = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic check_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
      rd_sel = idx;
      #1;
      check(tag, rd_data, exp);
   endtask

   // Legal instruction: accept, then DECODE, ISSUE, WB, back to IDLE.
   task automatic run(input logic [11:0] instr, input logic [7:0] exp_a,
                      input logic [7:0] exp_b, input string tag);
      in_valid = 1'b1;
      in_instr = instr;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " decode ready"}, in_ready, 1'b0);
      check({tag, " decode au_en"}, au_en, 1'b0);
      @(posedge clk); #1;
      check({tag, " issue au_en"}, au_en, 1'b1);
      check({tag, " issue au_ac"}, au_ac, instr[11:8]);
      check({tag, " issue au_a"}, au_a, exp_a);
      check({tag, " issue au_b"}, au_b, exp_b);
      @(posedge clk); #1;
      check({tag, " wb done"}, done, 1'b1);
      check({tag, " wb au_ac"}, au_ac, 4'b0000);
      last_done_cyc = cyc;
      @(posedge clk); #1;
      check({tag, " idle done"}, done, 1'b0);
      check({tag, " idle ready"}, in_ready, 1'b1);
   endtask

   int d1;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = 12'h000;
      rd_sel   = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst in_ready", in_ready, 1'b1);
      check("rst au_en", au_en, 1'b0);
      check("rst au_ac", au_ac, 4'h0);
      check("rst au_a", au_a, 8'h00);
      check("rst au_b", au_b, 8'h00);
      check("rst done", done, 1'b0);
      check("rst err", err, 1'b0);
      check("rst g_flag", g_flag, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00, "rst reg");

      // LDI R1=0x30, LDI R2=0x10 back to back.
      run(12'h570, 8'h30, 8'h00, "ldi r1");
      d1 = last_done_cyc;
      run(12'h590, 8'h10, 8'h00, "ldi r2");
      check("done spacing", last_done_cyc - d1, 4);
      check_reg(2'd1, 8'h30, "r1 ldi");
      check_reg(2'd2, 8'h10, "r2 ldi");

      // R1=0xF0 via 0x3C doubled twice, R2=0x20, then ADD R3=R1+R2 wraps.
      run(12'h57C, 8'h3C, 8'h00, "ldi r1 3c");
      run(12'h854, 8'h3C, 8'h3C, "add r1 dbl");
      run(12'h854, 8'h78, 8'h78, "add r1 dbl2");
      run(12'h5A0, 8'h20, 8'h00, "ldi r2 20");
      run(12'h8D8, 8'hF0, 8'h20, "add r3");
      check_reg(2'd3, 8'h10, "r3 add wrap");

      // SUB with srcA=0x05, srcB=0x80 -> 0x7B, g_flag 0.
      run(12'h545, 8'h05, 8'h00, "ldi r1 05");
      run(12'h8A8, 8'h20, 8'h20, "add r2 40");
      run(12'h8A8, 8'h40, 8'h40, "add r2 80");
      run(12'h9D8, 8'h05, 8'h80, "sub r3");
      check_reg(2'd3, 8'h7B, "r3 sub");
      check("sub g_flag 0", g_flag, 1'b0);

      // MOVG with g_flag=0 retires without writing R0.
      run(12'hD10, 8'h05, 8'h00, "movg g0");
      check_reg(2'd0, 8'h00, "r0 movg g0");

      // R2=0x85; SUB srcA=0x85 srcB=0x05 -> 0x80, g_flag 1.
      run(12'h8A4, 8'h80, 8'h05, "add r2 85");
      run(12'h9E4, 8'h85, 8'h05, "sub r3 b");
      check_reg(2'd3, 8'h80, "r3 sub b");
      check("sub g_flag 1", g_flag, 1'b1);
      run(12'hD20, 8'h85, 8'h00, "movg g1");
      check_reg(2'd0, 8'h85, "r0 movg g1");

      // Illegal opcode 0010 with in_valid held through the busy cycles.
      in_valid = 1'b1;
      in_instr = 12'h2D8;
      @(posedge clk); #1;
      check("ill decode err", err, 1'b0);
      check("ill decode ready", in_ready, 1'b0);
      @(posedge clk); #1;
      check("ill err pulse", err, 1'b1);
      check("ill au_en", au_en, 1'b0);
      check("ill ready busy", in_ready, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("ill err clear", err, 1'b0);
      check("ill ready back", in_ready, 1'b1);
      @(posedge clk); #1;
      check("ill no reaccept", in_ready, 1'b1);
      check("ill no done", done, 1'b0);
      check_reg(2'd3, 8'h80, "r3 after ill");
      check_reg(2'd0, 8'h85, "r0 after ill");
      check("g_flag after ill", g_flag, 1'b1);

      // Reset asserted during ISSUE of LDI R0=0x11.
      in_valid = 1'b1;
      in_instr = 12'h511;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre-rst issue au_en", au_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async rst ready", in_ready, 1'b1);
      check("async rst au_en", au_en, 1'b0);
      check("async rst au_ac", au_ac, 4'h0);
      check("async rst au_a", au_a, 8'h00);
      check("async rst g_flag", g_flag, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post rst no done", done, 1'b0);
      end
      check_reg(2'd0, 8'h00, "r0 after rst");
`ifdef DD_AU_SEQ_PERF_EN
      check("retired after rst", retired, 16'd0);
`endif
      run(12'h511, 8'h11, 8'h00, "ldi r0 11");
      run(12'h522, 8'h22, 8'h00, "ldi r0 22");
      check_reg(2'd0, 8'h22, "r0 final");
`ifdef DD_AU_SEQ_PERF_EN
      check("retired two", retired, 16'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
